// File: rtl/matrix_pkg.sv
// matrix_pkg: element/matrix widths, loader states and the shared operand packing order
package matrix_pkg;
    localparam int ELEM_W = 32;
    localparam int MAT_N = 2;
    localparam int MAT_W = MAT_N * MAT_N * ELEM_W;
    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
    // Row-major packing with element (0,0) in the MSBs
    function automatic int unsigned pack_off(input int unsigned row, input int unsigned col, input int unsigned w);
        return (MAT_N * MAT_N - 1 - (row * MAT_N + col)) * w;
    endfunction
endpackage

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: collects four A then four B elements and presents them as one packed operand pair
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int WIDTH = ELEM_W,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   clear,
    output logic [4*WIDTH-1:0]     A_out,
    output logic [4*WIDTH-1:0]     B_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_WIDTH-1:0]   pair_count
);
    state_t state, next_state;
    logic [1:0] idx;
    logic [4*WIDTH-1:0] a_stage, b_stage, a_next, b_next;
    logic accept, last, fire;
    int unsigned off;
    always_ff @(posedge clk)
        state <= rst ? LOAD_A : next_state;
    always_comb begin
        accept = in_valid && in_ready && !clear;
        last = accept && idx == 2'd3;
        fire = out_valid && out_ready;
        next_state = clear ? LOAD_A :
                     (state == LOAD_A && last) ? LOAD_B :
                     (state == LOAD_B && last) ? HOLD :
                     (state == HOLD && out_ready) ? LOAD_A : state;
    end
    always_comb begin
        in_ready = !rst && state != HOLD;
        out_valid = state == HOLD;
    end
    always_comb begin
        off = pack_off(32'(idx[1]), 32'(idx[0]), WIDTH);
        a_next = a_stage;
        b_next = b_stage;
        a_next[off +: WIDTH] = in_data;
        b_next[off +: WIDTH] = in_data;
    end
    // The 4th B element bypasses staging straight into B_out
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 2'd0;
            a_stage <= '0;
            b_stage <= '0;
            A_out <= '0;
            B_out <= '0;
            pair_count <= '0;
        end else begin
            idx <= (clear || next_state != state) ? 2'd0 : accept ? idx + 2'd1 : idx;
            if (accept && state == LOAD_A)
                a_stage <= a_next;
            if (accept && state == LOAD_B)
                b_stage <= b_next;
            if (last && state == LOAD_B) begin
                A_out <= a_stage;
                B_out <= b_next;
            end
            if (fire)
                pair_count <= pair_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: directed and random streams checked against a queue-based pair model
module tb_matrix_operand_loader;
    logic clk = 1'b0;
    logic rst, in_valid, clear, out_ready;
    logic [31:0] in_data;
    logic in_ready, out_valid, in_ready_w, out_valid_w;
    logic [127:0] A_out, B_out, A_w, B_w;
    logic [15:0] pair_count;
    logic [3:0] pair_count_w;
    int tests = 0, fails = 0;
    logic [31:0] q[$];
    bit hold = 0;
    logic [127:0] ma = '0, mb = '0;
    int unsigned mcnt = 0;

    always #5 clk = ~clk;

    matrix_operand_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .clear(clear), .A_out(A_out), .B_out(B_out), .out_valid(out_valid),
        .out_ready(out_ready), .pair_count(pair_count)
    );

    // Narrow counter instance exercises the modulo wrap within a short run
    matrix_operand_loader #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_w),
        .clear(clear), .A_out(A_w), .B_out(B_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .pair_count(pair_count_w)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit v, input logic [31:0] d, input bit ordy, input bit c);
        rst = r;
        in_valid = v;
        in_data = d;
        out_ready = ordy;
        clear = c;
        @(negedge clk);
        check("in_ready", in_ready, !r && !hold);
        check("out_valid", out_valid, hold);
        check("A_out", A_out, ma);
        check("B_out", B_out, mb);
        check("pair_count", pair_count, 16'(mcnt));
        check("in_ready_w", in_ready_w, !r && !hold);
        check("out_valid_w", out_valid_w, hold);
        check("A_w", A_w, ma);
        check("B_w", B_w, mb);
        check("pair_count_w", pair_count_w, 4'(mcnt));
        if (r) begin
            q.delete();
            hold = 0;
            ma = '0;
            mb = '0;
            mcnt = 0;
        end else begin
            if (hold && ordy)
                mcnt++;
            if (c) begin
                q.delete();
                hold = 0;
            end else if (hold) begin
                if (ordy)
                    hold = 0;
            end else if (v) begin
                q.push_back(d);
                if (q.size() == 8) begin
                    ma = {q[0], q[1], q[2], q[3]};
                    mb = {q[4], q[5], q[6], q[7]};
                    q.delete();
                    hold = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 3, 1, 0);
        for (int i = 1; i <= 8; i++)
            cyc(0, 1, 32'(i), 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("seq_A", A_out, 128'h00000001_00000002_00000003_00000004);
        check("seq_B", B_out, 128'h00000005_00000006_00000007_00000008);
        check("seq_cnt", pair_count, 128'd1);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, (i % 2 != 0) ? 32'h80000000 : 32'hFFFFFFFF, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 32'd99, 0, 0);
        cyc(0, 1, 32'd99, 1, 0);
        check("neg_A", A_out, 128'hFFFFFFFF_80000000_FFFFFFFF_80000000);
        check("neg_B", B_out, 128'hFFFFFFFF_80000000_FFFFFFFF_80000000);
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 32'(50 + i), 1, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 10; i <= 17; i++)
            cyc(0, 1, 32'(i), 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("clr_A", A_out, 128'h0000000A_0000000B_0000000C_0000000D);
        check("clr_B", B_out, 128'h0000000E_0000000F_00000010_00000011);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 32'(20 + i), 1, 0);
        cyc(0, 1, 32'd77, 1, 1);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 32'(30 + i), 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 32'(40 + i), 0, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 32'(60 + i), 1, 0);
        cyc(1, 1, 32'd5, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("rst_cnt", pair_count, 128'd0);
        for (int i = 0; i < 4000; i++)
            cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
